// File: rtl/aes_enc_arbiter_pkg.sv
// aes_arb_pkg: FSM state encoding, key-length codes and watchdog default for the AES encipher arbiter.
package aes_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_LO, WAIT_HI} arb_state_e;
  localparam logic AES_128_BIT_KEY = 1'b0;
  localparam logic AES_256_BIT_KEY = 1'b1;
  localparam logic [7:0] WDOG_CYCLES_DEF = 8'd200;
endpackage

// File: rtl/aes_enc_arbiter_if.sv
// aes_enc_arbiter_if: requester and encipher-core signals; master drives requests and the core, slave is the arbiter.
interface aes_enc_arbiter_if;
  logic req0, req1;
  logic [127:0] block0, block1;
  logic keylen;
  logic done0, done1;
  logic [127:0] result;
  logic busy, grant_id, enc_next;
  logic [127:0] enc_block;
  logic enc_keylen, enc_ready;
  logic [127:0] enc_new_block;
  logic wdog_err;
  modport master (
    output req0, req1, block0, block1, keylen, enc_ready, enc_new_block,
    input done0, done1, result, busy, grant_id, enc_next, enc_block, enc_keylen, wdog_err
  );
  modport slave (
    input req0, req1, block0, block1, keylen, enc_ready, enc_new_block,
    output done0, done1, result, busy, grant_id, enc_next, enc_block, enc_keylen, wdog_err
  );
endinterface

// File: rtl/aes_enc_arbiter_rr.sv
// aes_rr_arb2: combinational two-way round-robin grant; a tie goes to the requester not served last.
module aes_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_id
);
  always_comb begin
    gnt_valid = |req;
    gnt_id = &req ? ~last_grant : req[1];
  end
endmodule

// File: rtl/aes_enc_arbiter.sv
// aes_enc_arbiter: shares one AES encipher core between two requesters; watchdog built only with AES_ARB_WATCHDOG_EN.
module aes_enc_arbiter
  import aes_arb_pkg::*;
#(
  parameter logic [7:0] WDOG_CYCLES = WDOG_CYCLES_DEF
) (
  input logic clk,
  input logic reset_n,
  aes_enc_arbiter_if.slave bus
);
  arb_state_e state;
  logic last_grant, gnt_valid, gnt_id, wdog_trip;
  aes_rr_arb2 u_rr (
    .req       ({bus.req1, bus.req0}),
    .last_grant(last_grant),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );
`ifdef AES_ARB_WATCHDOG_EN
  logic [7:0] wdog_cnt;
  logic in_wait;
  assign in_wait = (state == WAIT_LO) || (state == WAIT_HI);
  assign wdog_trip = in_wait && (wdog_cnt == WDOG_CYCLES - 8'd1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wdog_cnt <= 8'd0;
      bus.wdog_err <= 1'b0;
    end else begin
      wdog_cnt <= (state == ISSUE) ? 8'd0 : in_wait ? wdog_cnt + 8'd1 : wdog_cnt;
      bus.wdog_err <= bus.wdog_err | wdog_trip;
    end
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_CYCLES;
  assign wdog_trip = 1'b0;
  assign bus.wdog_err = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      last_grant <= 1'b1;
      bus.done0 <= 1'b0;
      bus.done1 <= 1'b0;
      bus.enc_next <= 1'b0;
      bus.busy <= 1'b0;
      bus.grant_id <= 1'b0;
      bus.result <= '0;
      bus.enc_block <= '0;
      bus.enc_keylen <= AES_128_BIT_KEY;
    end else begin
      bus.done0 <= 1'b0;
      bus.done1 <= 1'b0;
      bus.enc_next <= 1'b0;
      if (wdog_trip) begin
        state <= IDLE;
        bus.busy <= 1'b0;
        bus.result <= '0;
        bus.done0 <= ~bus.grant_id;
        bus.done1 <= bus.grant_id;
        last_grant <= bus.grant_id;
      end else begin
        case (state)
          // the done cycle is skipped so a requester still holding req is not re-granted
          IDLE: if (gnt_valid && bus.enc_ready && !bus.done0 && !bus.done1) begin
            state <= ISSUE;
            bus.busy <= 1'b1;
            bus.enc_next <= 1'b1;
            bus.grant_id <= gnt_id;
            bus.enc_block <= gnt_id ? bus.block1 : bus.block0;
            bus.enc_keylen <= bus.keylen;
          end
          ISSUE: state <= WAIT_LO;
          WAIT_LO: if (!bus.enc_ready) state <= WAIT_HI;
          WAIT_HI: if (bus.enc_ready) begin
            state <= IDLE;
            bus.busy <= 1'b0;
            bus.result <= bus.enc_new_block;
            bus.done0 <= ~bus.grant_id;
            bus.done1 <= bus.grant_id;
            last_grant <= bus.grant_id;
          end
          default: state <= IDLE;
        endcase
      end
    end
endmodule

// File: tb/tb_aes_enc_arbiter.sv
// tb_aes_enc_arbiter: scoreboard bench with a stub encipher core returning FIPS-197 vectors or ~block.
module tb_aes_enc_arbiter;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] B0 = 128'h0123456789abcdef_fedcba9876543210;
  localparam logic [127:0] NB0 = 128'hfedcba9876543210_0123456789abcdef;
  localparam logic [127:0] B1 = 128'h0;
  localparam logic [127:0] NB1 = 128'hffffffffffffffff_ffffffffffffffff;
  typedef struct {logic id; logic [127:0] res;} exp_t;
  logic clk = 1'b0;
  logic reset_n;
  logic hang, chk_kl, exp_kl, prev_next;
  int stub_lat, lat_cnt, nexts;
  int errors = 0;
  int checks = 0;
  exp_t sb[$];
  aes_enc_arbiter_if bus();
  aes_enc_arbiter #(.WDOG_CYCLES(8'd20)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [127:0] stub_aes(input logic [127:0] b, input logic kl);
    if (b == PT) return kl ? CT256 : CT128;
    return ~b;
  endfunction
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      bus.enc_ready <= 1'b1;
      bus.enc_new_block <= '0;
      lat_cnt <= 0;
    end else if (bus.enc_next) begin
      bus.enc_ready <= 1'b0;
      lat_cnt <= stub_lat;
    end else if (!bus.enc_ready && !hang) begin
      if (lat_cnt == 0) begin
        bus.enc_ready <= 1'b1;
        bus.enc_new_block <= stub_aes(bus.enc_block, bus.enc_keylen);
      end else lat_cnt <= lat_cnt - 1;
    end
  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (bus.done0 && bus.done1) check("done_exclusive", 2'b11, 2'b00);
      if (bus.done0 || bus.done1) begin
        if (sb.size() == 0) check("unexpected_done", {bus.done1, bus.done0}, 2'b00);
        else begin
          e = sb.pop_front();
          check("done_id", bus.done1, e.id);
          check("grant_id", bus.grant_id, e.id);
          check("result", bus.result, e.res);
        end
      end
      if (bus.enc_next) begin
        nexts++;
        if (prev_next) check("enc_next_width", 2'b11, 2'b01);
      end
      if (bus.busy && chk_kl) check("enc_keylen", bus.enc_keylen, exp_kl);
    end
    prev_next = bus.enc_next;
  end
  task automatic push(input logic id, input logic [127:0] res);
    exp_t e;
    e.id = id;
    e.res = res;
    sb.push_back(e);
  endtask
  task automatic wait_done(input string nm);
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!(bus.done0 || bus.done1) && c < 500);
    if (c >= 500) check({nm, "_timeout"}, 0, 1);
  endtask
  task automatic wait_next(input string nm);
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!bus.enc_next && c < 500);
    if (c >= 500) check({nm, "_timeout"}, 0, 1);
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask
  task automatic job(input logic id, input logic [127:0] blk, input logic kl, input logic [127:0] exp, input string nm);
    @(posedge clk);
    #1;
    if (id) bus.block1 = blk;
    else bus.block0 = blk;
    bus.keylen = kl;
    exp_kl = kl;
    chk_kl = 1'b1;
    push(id, exp);
    if (id) bus.req1 = 1'b1;
    else bus.req0 = 1'b1;
    wait_done(nm);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    chk_kl = 1'b0;
  endtask
  initial begin
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.block0 = '0;
    bus.block1 = '0;
    bus.keylen = 1'b0;
    hang = 1'b0;
    chk_kl = 1'b0;
    exp_kl = 1'b0;
    prev_next = 1'b0;
    stub_lat = 4;
    nexts = 0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", {bus.done0, bus.done1, bus.enc_next, bus.busy, bus.grant_id, bus.enc_keylen, bus.wdog_err}, 0);
    check("rst_result", bus.result, 0);
    check("rst_enc_block", bus.enc_block, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    job(1'b0, PT, 1'b0, CT128, "aes128");
    do_reset();
    bus.block0 = B0;
    bus.block1 = B1;
    bus.keylen = 1'b0;
    push(1'b0, NB0);
    push(1'b1, NB1);
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    wait_done("tie_first");
    bus.req0 = 1'b0;
    wait_done("tie_second");
    bus.req1 = 1'b0;
    nexts = 0;
    for (int i = 0; i < 6; i++) push(i[0], i[0] ? NB1 : NB0);
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    for (int i = 0; i < 6; i++) wait_done("fair");
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (4) @(negedge clk);
    check("fair_enc_next_count", nexts, 6);
    push(1'b1, NB1);
    bus.req1 = 1'b1;
    wait_next("drop_next");
    bus.req1 = 1'b0;
    push(1'b0, NB0);
    bus.req0 = 1'b1;
    wait_done("drop_done");
    wait_done("queued_done");
    bus.req0 = 1'b0;
    stub_lat = 10;
    bus.block0 = B0;
    bus.req0 = 1'b1;
    wait_next("midrst_next");
    repeat (4) @(negedge clk);
    check("midrst_busy_before", bus.busy, 1);
    reset_n = 1'b0;
    bus.req0 = 1'b0;
    @(negedge clk);
    check("midrst_busy", bus.busy, 0);
    check("midrst_wdog", bus.wdog_err, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (6) @(negedge clk);
    check("midrst_idle", {bus.busy, bus.done0, bus.done1}, 0);
    stub_lat = 4;
    job(1'b1, B1, 1'b0, NB1, "after_rst");
    job(1'b0, PT, 1'b1, CT256, "aes256");
`ifdef AES_ARB_WATCHDOG_EN
    begin
      int t = 0;
      hang = 1'b1;
      push(1'b0, 128'h0);
      bus.block0 = PT;
      bus.keylen = 1'b0;
      bus.req0 = 1'b1;
      wait_next("wdog_next");
      while (!bus.wdog_err && t < 100) begin
        @(negedge clk);
        t++;
      end
      bus.req0 = 1'b0;
      check("wdog_latency", (t >= 20 && t <= 22), 1);
      check("wdog_done", bus.done0, 1);
      repeat (3) @(negedge clk);
      check("wdog_sticky", {bus.wdog_err, bus.busy}, 2'b10);
      hang = 1'b0;
      do_reset();
      @(negedge clk);
      check("wdog_cleared", bus.wdog_err, 0);
    end
`endif
    repeat (4) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
